// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: widths, reset PC and FSM encodings.
package ifu_fetch_pkg;
  localparam int XLEN      = 64;
  localparam int INST_W    = 32;
  localparam int InstWidth = INST_W;
  localparam logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_e;
endpackage

// File: rtl/ifu_fetch_if.sv
// Bundle of the fetch stage's memory, redirect and decoder-facing handshakes.
interface ifu_fetch_if;
  import ifu_fetch_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [XLEN-1:0]   out_pc;

  // master is the fetch stage itself; slave is the memory/execute/decoder side
  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/ifu_pc_reg.sv
// Architectural PC: redirect beats increment; redirect targets are forced word aligned.
module ifu_pc_reg
  import ifu_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR = RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] target,
  input  logic            incr,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           pc <= RESET_ADDR;
    else if (redirect) pc <= {target[XLEN-1:2], 2'b00};
    else if (incr)     pc <= pc + XLEN'(4);
  end

endmodule

// File: rtl/ifu_fetch.sv
// Non-prefetching fetch stage: one outstanding request, one instruction held for the decoder.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR = RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  ifu_fetch_if.master fetch
);

  state_e            state, state_nxt;
  logic              drop, drop_nxt;
  logic              incr, load_out, clr_out;
  logic [XLEN-1:0]   pc;
  logic              out_valid_q;
  logic [INST_W-1:0] out_inst_q;
  logic [XLEN-1:0]   out_pc_q;

  ifu_pc_reg #(.RESET_ADDR(RESET_ADDR)) u_pc (
    .clk      (clk),
    .rst      (rst),
    .redirect (fetch.redirect_valid),
    .target   (fetch.redirect_pc),
    .incr     (incr),
    .pc       (pc)
  );

  // rst gates the request directly so memory never sees a request during reset
  assign fetch.imem_req_valid = ~rst & (state == S_REQ) & ~fetch.redirect_valid;
  assign fetch.imem_req_addr  = pc;
  assign fetch.out_valid      = out_valid_q;
  assign fetch.out_inst       = out_inst_q;
  assign fetch.out_pc         = out_pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_REQ;
      drop        <= 1'b0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
    end else begin
      state <= state_nxt;
      drop  <= drop_nxt;
      if (load_out) begin
        out_valid_q <= 1'b1;
        out_inst_q  <= fetch.imem_rsp_data;
        out_pc_q    <= pc;
      end else if (clr_out) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    drop_nxt  = drop;
    incr      = 1'b0;
    load_out  = 1'b0;
    clr_out   = 1'b0;
    case (state)
      S_REQ: begin
        if (fetch.imem_req_valid && fetch.imem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (fetch.redirect_valid) begin
          // a response landing with the redirect is stale and consumes the request
          if (fetch.imem_rsp_valid) begin
            drop_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else begin
            drop_nxt  = 1'b1;
          end
        end else if (fetch.imem_rsp_valid) begin
          if (drop) begin
            drop_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else begin
            load_out  = 1'b1;
            state_nxt = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (fetch.redirect_valid) begin
          clr_out   = 1'b1;
          state_nxt = S_REQ;
        end else if (fetch.out_ready) begin
          clr_out   = 1'b1;
          incr      = 1'b1;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage that sits directly upstream of the decoder.
- Holds the architectural PC and issues one 32-bit fetch per instruction to the instruction memory port.
- Presents the fetched instruction and its PC to the decoder through a valid/ready handshake.
- Accepts PC redirects from execute for jal/jalr and, later, branches; in-flight work is flushed on redirect.

Parameters:
- XLEN, 64, PC and address width.
- INST_W, 32, instruction width.
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  fetch address; always equals the current PC.
- imem_rsp_valid  in  1  read data valid; a single-cycle pulse.
- imem_rsp_data  in  INST_W  fetched instruction.
- redirect_valid  in  1  execute requests a PC change.
- redirect_pc  in  XLEN  redirect target.
- out_valid  out  1  instruction available to the decoder.
- out_ready  in  1  decoder consumes the instruction.
- out_inst  out  INST_W  instruction to the decoder.
- out_pc  out  XLEN  PC of out_inst.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - pc = RESET_PC.
  - state = S_REQ.
  - drop = 0.
  - out_valid = 0, out_inst = 0, out_pc = 0.
  - imem_req_valid deasserts combinationally while rst is high.
- Outstanding requests: at most one fetch is outstanding at any time. The memory never returns a response without a prior accepted request.
- States:
  - S_REQ:
    - imem_req_valid = ~redirect_valid.
    - On req_valid & req_ready, go to S_WAIT.
  - S_WAIT:
    - On imem_rsp_valid with drop=0: capture out_inst=rsp_data and out_pc=pc, set out_valid=1, go to S_OUT.
    - On imem_rsp_valid with drop=1: discard the data, clear drop, go to S_REQ.
    - A response may arrive the cycle after acceptance. Minimum request-to-out_valid latency is 2 cycles (same-cycle ready, next-cycle response).
  - S_OUT:
    - Hold out_* stable until out_valid & out_ready.
    - On that handshake: pc <= pc + 4, out_valid <= 0, go to S_REQ.
    - No new request is issued while in S_OUT. There is no prefetch; throughput is at most one instruction per 3 cycles.
- Redirect (priority over all other events in the same cycle):
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}; the low bits are forced to zero.
  - In S_REQ: the request is suppressed that cycle (req_valid=0). Stay in S_REQ and fetch from the new PC next cycle.
  - In S_WAIT without a response this cycle: set drop=1 and stay in S_WAIT.
  - In S_WAIT with a response this cycle: discard the response, drop stays 0, go to S_REQ.
  - In S_OUT: out_valid <= 0 even if out_ready is high that cycle; the instruction is not consumed and the pc+4 update is skipped. Go to S_REQ.
- Arithmetic: pc + 4 wraps modulo 2^XLEN with no flag.
- Reset mid-operation: all state returns to reset values immediately. A response that arrives after reset deasserts must not happen, since the memory is reset together with this block.
- Unused state encodings recover to S_REQ.

Decomposition:
- Add to the shared defines include:
  - state encodings S_REQ=2'd0, S_WAIT=2'd1, S_OUT=2'd2;
  - RESET_PC default;
  - inst-width and XLEN macros alongside the existing InstWidth.
- One natural sub-module, ifu_pc_reg: the PC register with its reset, redirect and increment muxing.

Test Plan:
- Reset release, req_ready=1, response 1 cycle later with 32'h00000413, out_ready=1 -> imem_req_addr=0x80000000; out_inst=0x00000413 and out_pc=0x80000000 exactly 2 cycles after the request; next request addr 0x80000004.
- out_ready held 0 for 5 cycles in S_OUT -> out_valid, out_inst and out_pc stable; no imem_req_valid; pc advances only after out_ready rises.
- req_ready low for 3 cycles -> imem_req_valid stays 1 with a stable address; no state change until acceptance.
- Redirect to 0x80001002 while in S_WAIT, response arriving 2 cycles later -> response dropped; out_valid never asserts for it; next request addr 0x80001000.
- Redirect in S_OUT concurrent with out_ready=1 (out_pc=0x80000008) -> no handshake counted; out_valid falls; next fetch at the redirect target, not 0x8000000C.
- rst asserted during S_WAIT -> out_valid=0 and req_valid=0 immediately; after release the first request addr is 0x80000000.
